// File: rtl/adat_frame_lock_controller_if.sv
// ---------------------------------------------------------------------------
// Link between the NRZI phase-lock decoder and the ADAT frame lock controller.
// Signal suffixes are named from the controller's point of view.
// ---------------------------------------------------------------------------
interface adat_frame_lock_controller_if;
   // decoder -> controller
   logic       dec_tick_ni;
   logic       dec_data_i;
   logic       dec_valid_i;
   logic       dec_sync_i;
   // controller -> decoder / deserialiser
   logic       dec_resync_o;
   logic       locked_o;
   logic       frame_start_o;
   logic [7:0] bit_index_o;
   logic [3:0] user_bits_o;
   logic       frame_err_o;
   logic [7:0] err_cnt_o;

   // decoder side (and testbench)
   modport master (
      output dec_tick_ni, dec_data_i, dec_valid_i, dec_sync_i,
      input  dec_resync_o, locked_o, frame_start_o, bit_index_o,
             user_bits_o, frame_err_o, err_cnt_o
   );

   // frame lock controller side
   modport slave (
      input  dec_tick_ni, dec_data_i, dec_valid_i, dec_sync_i,
      output dec_resync_o, locked_o, frame_start_o, bit_index_o,
             user_bits_o, frame_err_o, err_cnt_o
   );
endinterface

// File: rtl/adat_frame_lock_controller.sv
// ---------------------------------------------------------------------------
// ADAT frame lock controller.
// Consumes the recovered bit stream of the NRZI decoder, searches for the
// 256-bit frame sync, verifies a number of clean frames, then tracks the
// frame with a flywheel bit index. Requests decoder re-acquisition when lock
// is lost, when no sync is found in time, or when the decoder stalls.
// ---------------------------------------------------------------------------
module adat_frame_lock_controller #(
   parameter int unsigned LOCK_FRAMES         = 4,
   parameter int unsigned UNLOCK_FRAMES       = 3,
   parameter int unsigned SYNC_ZEROS          = 10,
   parameter int unsigned SEARCH_TIMEOUT_BITS = 768,
   parameter int unsigned TICK_TIMEOUT_CLKS   = 64
) (
   input  logic                           clk_x4_i,
   input  logic                           rst_ni,
   adat_frame_lock_controller_if.slave    bus
);

   localparam int unsigned ZR_W = $clog2(SYNC_ZEROS + 1);
   localparam int unsigned SC_W = $clog2(SEARCH_TIMEOUT_BITS + 1);
   localparam int unsigned WD_W = $clog2(TICK_TIMEOUT_CLKS + 1);

   typedef enum logic [1:0] {
      ST_SEARCH,
      ST_VERIFY,
      ST_LOCKED
   } state_e;

   state_e            state_q;
   logic [7:0]        idx_q;
   logic [ZR_W-1:0]   zero_run_q;
   logic [SC_W-1:0]   search_cnt_q;
   logic [WD_W-1:0]   wd_q;
   logic [3:0]        good_q;
   logic [3:0]        bad_q;
   logic              frame_bad_q;
   logic [3:0]        ub_shift_q;
   logic              resync_q;
   logic              locked_q;
   logic              frame_start_q;
   logic [3:0]        user_bits_q;
   logic              frame_err_q;
   logic [7:0]        err_cnt_q;

   logic              tick;
   logic [1:0]        fixed;
   logic              viol;
   logic              lost;
   logic [7:0]        err_cnt_d;
   logic [ZR_W-1:0]   zero_run_d;
   logic [3:0]        good_d;
   logic [3:0]        bad_d;
   logic              frame_bad_d;

   // Fixed-bit map of the frame: {position is fixed, required value}.
   function automatic logic [1:0] fixed_bit(input logic [7:0] idx);
      if (idx == 8'd255)
         return 2'b11;                                  // sync
      if (idx >= 8'd245)
         return 2'b10;                                  // sync zero run
      if (idx >= 8'd4 && idx <= 8'd244 && ((idx - 8'd4) % 8'd5) == 8'd0)
         return 2'b11;                                  // nibble separator
      return 2'b00;                                     // user / audio
   endfunction

   // Per-bit decode: violation detect, lock-loss detect and counter increments.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      tick        = ~bus.dec_tick_ni;
      fixed       = fixed_bit(idx_q);
      viol        = ~bus.dec_valid_i | (fixed[1] & (bus.dec_data_i != fixed[0]));
      lost        = (state_q != ST_SEARCH) &&
                    (~bus.dec_sync_i || (~tick && wd_q == WD_W'(TICK_TIMEOUT_CLKS - 1)));
      err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
      zero_run_d  = '0;
      if (bus.dec_valid_i && !bus.dec_data_i)
         zero_run_d = (zero_run_q >= ZR_W'(SYNC_ZEROS)) ? zero_run_q : zero_run_q + 1'b1;
      good_d      = good_q + 4'd1;
      bad_d       = bad_q + 4'd1;
      frame_bad_d = frame_bad_q | viol;
   end

   // Frame lock state machine with registered outputs.
   always_ff @(posedge clk_x4_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_SEARCH;
         idx_q         <= '0;
         zero_run_q    <= '0;
         search_cnt_q  <= '0;
         wd_q          <= '0;
         good_q        <= '0;
         bad_q         <= '0;
         frame_bad_q   <= 1'b0;
         ub_shift_q    <= '0;
         resync_q      <= 1'b0;
         locked_q      <= 1'b0;
         frame_start_q <= 1'b0;
         user_bits_q   <= '0;
         frame_err_q   <= 1'b0;
         err_cnt_q     <= '0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
         resync_q      <= 1'b0;
         frame_start_q <= 1'b0;
         frame_err_q   <= 1'b0;

         if (lost) begin
            // decoder lost phase sync or stalled: drop everything, restart it
            state_q      <= ST_SEARCH;
            locked_q     <= 1'b0;
            resync_q     <= 1'b1;
            idx_q        <= '0;
            zero_run_q   <= '0;
            search_cnt_q <= '0;
            wd_q         <= '0;
            bad_q        <= '0;
            frame_bad_q  <= 1'b0;
         end else if (!tick) begin
            if (state_q != ST_SEARCH)
               wd_q <= wd_q + 1'b1;
         end else begin
            wd_q <= '0;
            if (state_q != ST_SEARCH && idx_q < 8'd4)
               ub_shift_q <= {ub_shift_q[2:0], bus.dec_data_i};

            case (state_q)
               ST_SEARCH: begin
                  if (bus.dec_valid_i && bus.dec_data_i && zero_run_q >= ZR_W'(SYNC_ZEROS)) begin
                     state_q      <= ST_VERIFY;
                     idx_q        <= '0;
                     good_q       <= '0;
                     frame_bad_q  <= 1'b0;
                     zero_run_q   <= '0;
                     search_cnt_q <= '0;
                  end else begin
                     zero_run_q <= zero_run_d;
                     if (search_cnt_q == SC_W'(SEARCH_TIMEOUT_BITS - 1)) begin
                        resync_q     <= 1'b1;
                        search_cnt_q <= '0;
                     end else begin
                        search_cnt_q <= search_cnt_q + 1'b1;
                     end
                  end
               end

               ST_VERIFY: begin
                  if (viol) begin
                     // any error while verifying: back to search, this bit starts the zero run
                     frame_err_q  <= 1'b1;
                     err_cnt_q    <= err_cnt_d;
                     state_q      <= ST_SEARCH;
                     idx_q        <= '0;
                     zero_run_q   <= (bus.dec_valid_i && !bus.dec_data_i) ? ZR_W'(1) : '0;
                     search_cnt_q <= '0;
                  end else if (idx_q == 8'd255) begin
                     idx_q  <= '0;
                     good_q <= good_d;
                     if (good_d == 4'(LOCK_FRAMES)) begin
                        state_q       <= ST_LOCKED;
                        locked_q      <= 1'b1;
                        frame_start_q <= 1'b1;
                        user_bits_q   <= ub_shift_q;
                        bad_q         <= '0;
                        frame_bad_q   <= 1'b0;
                     end
                  end else begin
                     idx_q <= idx_q + 8'd1;
                  end
               end

               ST_LOCKED: begin
                  // only the first violation of a frame is reported
                  if (viol && !frame_bad_q) begin
                     frame_err_q <= 1'b1;
                     err_cnt_q   <= err_cnt_d;
                  end
                  if (idx_q == 8'd255) begin
                     idx_q       <= '0;
                     frame_bad_q <= 1'b0;
                     if (frame_bad_d) begin
                        if (bad_d == 4'(UNLOCK_FRAMES)) begin
                           state_q      <= ST_SEARCH;
                           locked_q     <= 1'b0;
                           resync_q     <= 1'b1;
                           bad_q        <= '0;
                           zero_run_q   <= '0;
                           search_cnt_q <= '0;
                        end else begin
                           bad_q <= bad_d;
                        end
                     end else begin
                        bad_q         <= '0;
                        user_bits_q   <= ub_shift_q;
                        frame_start_q <= 1'b1;
                     end
                  end else begin
                     // flywheel: the index advances even through errors
                     idx_q       <= idx_q + 8'd1;
                     frame_bad_q <= frame_bad_d;
                  end
               end

               default: begin
                  state_q <= ST_SEARCH;
                  idx_q   <= '0;
               end
            endcase
         end
      end
   end

   assign bus.dec_resync_o  = resync_q;
   assign bus.locked_o      = locked_q;
   assign bus.frame_start_o = frame_start_q;
   assign bus.bit_index_o   = idx_q;
   assign bus.user_bits_o   = user_bits_q;
   assign bus.frame_err_o   = frame_err_q;
   assign bus.err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_adat_frame_lock_controller.sv
// ---------------------------------------------------------------------------
// Testbench for adat_frame_lock_controller.
// Directed ADAT streams; expected pulse events (kind + bit number) are queued
// as stimulus is driven and matched by a monitor as the DUT pulses.
// ---------------------------------------------------------------------------
module tb_adat_frame_lock_controller;

   typedef enum int {EV_NONE, EV_ERR, EV_START, EV_RESYNC} ev_kind_e;
   typedef struct {
      ev_kind_e kind;
      int       tick;
   } ev_t;

   logic clk_x4_i = 1'b0;
   logic rst_ni   = 1'b0;
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   tick_cnt = 0;
   ev_t  exp_q[$];

   adat_frame_lock_controller_if bus ();

   adat_frame_lock_controller dut (
      .clk_x4_i (clk_x4_i),
      .rst_ni   (rst_ni),
      .bus      (bus.slave)
   );

   always #5 clk_x4_i = ~clk_x4_i;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   // Frame content as transmitted, user nibble sent MSB first.
   function automatic logic frame_bit(input int i, input logic [3:0] user);
      if (i < 4)                                   return user[3-i];
      if (i == 255)                                return 1'b1;
      if (i >= 245)                                return 1'b0;
      if (i <= 244 && ((i - 4) % 5) == 0)          return 1'b1;
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic send_bit(input logic d, input logic v);
      bus.dec_data_i  = d;
      bus.dec_valid_i = v;
      bus.dec_tick_ni = 1'b0;
      tick_cnt++;
      @(negedge clk_x4_i);
      bus.dec_tick_ni = 1'b1;
      repeat (3) @(negedge clk_x4_i);
   endtask

   task automatic send_frame(input logic [3:0] user, input int flip_idx, input int n_bits,
                             input bit exp_err, input bit exp_start, input bit exp_resync);
      int base;
      base = tick_cnt;
      if (exp_err)    exp_q.push_back('{EV_ERR,    base + 1 + flip_idx});
      if (exp_start)  exp_q.push_back('{EV_START,  base + 256});
      if (exp_resync) exp_q.push_back('{EV_RESYNC, base + 256});
      for (int i = 0; i < n_bits; i++)
         send_bit(frame_bit(i, user) ^ (i == flip_idx), 1'b1);
   endtask

   task automatic match_event(input ev_kind_e k, input string name);
      ev_t e;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = '{EV_NONE, -1};
      check({name, "_kind"}, 32'(int'(k)), 32'(int'(e.kind)));
      check({name, "_tick"}, 32'(tick_cnt), 32'(e.tick));
   endtask

   // Monitor: every output pulse must match the next queued expectation.
   initial begin
      forever begin
         @(negedge clk_x4_i);
         if (bus.frame_err_o)   match_event(EV_ERR,    "ev_frame_err");
         if (bus.frame_start_o) match_event(EV_START,  "ev_frame_start");
         if (bus.dec_resync_o)  match_event(EV_RESYNC, "ev_resync");
      end
   end

   initial begin
      bus.dec_tick_ni = 1'b1;
      bus.dec_data_i  = 1'b0;
      bus.dec_valid_i = 1'b1;
      bus.dec_sync_i  = 1'b1;
      repeat (3) @(negedge clk_x4_i);

      // reset state
      check("rst_locked",    bus.locked_o,      0);
      check("rst_resync",    bus.dec_resync_o,  0);
      check("rst_start",     bus.frame_start_o, 0);
      check("rst_idx",       bus.bit_index_o,   0);
      check("rst_user",      bus.user_bits_o,   0);
      check("rst_err",       bus.frame_err_o,   0);
      check("rst_err_cnt",   bus.err_cnt_o,     0);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_x4_i);

      // clean stream: lock after frame 4, frame_start on each later frame
      for (int f = 0; f < 10; f++) begin
         send_frame(4'hA, -1, 256, 1'b0, f >= 4, 1'b0);
         check($sformatf("lock_f%0d", f), bus.locked_o, (f >= 4) ? 1 : 0);
      end
      check("clean_user",    bus.user_bits_o, 4'hA);
      check("clean_err_cnt", bus.err_cnt_o,   0);
      check("clean_idx",     bus.bit_index_o, 0);

      // separator at idx 9 forced to 0: single error, lock held
      send_frame(4'hA, 9, 256, 1'b1, 1'b0, 1'b0);
      check("sep_locked",  bus.locked_o,  1);
      check("sep_err_cnt", bus.err_cnt_o, 1);
      send_frame(4'hA, -1, 256, 1'b0, 1'b1, 1'b0);
      check("sep_recover", bus.locked_o,  1);

      // three frames with idx 250 forced to 1: lock drops at third idx 255
      send_frame(4'hA, 250, 256, 1'b1, 1'b0, 1'b0);
      send_frame(4'hA, 250, 256, 1'b1, 1'b0, 1'b0);
      check("unlock_still_locked", bus.locked_o, 1);
      send_frame(4'hA, 250, 256, 1'b1, 1'b0, 1'b1);
      check("unlock_locked",  bus.locked_o,    0);
      check("unlock_err_cnt", bus.err_cnt_o,   4);
      check("unlock_user",    bus.user_bits_o, 4'hA);
      check("unlock_idx",     bus.bit_index_o, 0);

      // 768 bits without a valid sync: one resync on the 768th tick
      begin
         int   zr;
         logic b;
         zr = 0;
         exp_q.push_back('{EV_RESYNC, tick_cnt + 768});
         for (int i = 0; i < 768; i++) begin
            b  = (zr >= 9) ? 1'b1 : 1'($urandom_range(0, 1));
            zr = b ? 0 : zr + 1;
            send_bit(b, 1'b1);
         end
      end
      check("timeout_locked", bus.locked_o,    0);
      check("timeout_idx",    bus.bit_index_o, 0);

      // relock, then stop ticks: lock drops on the 64th tick-less clock
      for (int f = 0; f < 5; f++) send_frame(4'hA, -1, 256, 1'b0, f == 4, 1'b0);
      check("relock1", bus.locked_o, 1);
      exp_q.push_back('{EV_RESYNC, tick_cnt});
      repeat (60) @(negedge clk_x4_i);
      check("wd_63clk_locked", bus.locked_o, 1);
      @(negedge clk_x4_i);
      check("wd_64clk_locked", bus.locked_o, 0);

      // relock, then drop dec_sync_i mid-frame together with a bit
      for (int f = 0; f < 5; f++) send_frame(4'hA, -1, 256, 1'b0, f == 4, 1'b0);
      check("relock2", bus.locked_o, 1);
      send_frame(4'hA, -1, 100, 1'b0, 1'b0, 1'b0);
      check("mid_idx", bus.bit_index_o, 100);
      bus.dec_sync_i  = 1'b0;
      bus.dec_data_i  = 1'b1;
      bus.dec_tick_ni = 1'b0;
      tick_cnt++;
      exp_q.push_back('{EV_RESYNC, tick_cnt});
      @(negedge clk_x4_i);
      check("sync_loss_locked", bus.locked_o,    0);
      check("sync_loss_idx",    bus.bit_index_o, 0);
      bus.dec_tick_ni = 1'b1;
      repeat (3) @(negedge clk_x4_i);
      bus.dec_sync_i = 1'b1;

      // relock, then reset mid-frame: outputs clear immediately
      for (int f = 0; f < 5; f++) send_frame(4'hA, -1, 256, 1'b0, f == 4, 1'b0);
      check("relock3", bus.locked_o, 1);
      send_frame(4'hA, -1, 50, 1'b0, 1'b0, 1'b0);
      #1 rst_ni = 1'b0;
      #1;
      check("mid_rst_locked",  bus.locked_o,    0);
      check("mid_rst_idx",     bus.bit_index_o, 0);
      check("mid_rst_user",    bus.user_bits_o, 0);
      check("mid_rst_err_cnt", bus.err_cnt_o,   0);
      @(negedge clk_x4_i);
      rst_ni = 1'b1;
      @(negedge clk_x4_i);
      for (int f = 0; f < 5; f++) begin
         send_frame(4'h5, -1, 256, 1'b0, f == 4, 1'b0);
         check($sformatf("post_rst_lock_f%0d", f), bus.locked_o, (f == 4) ? 1 : 0);
      end
      check("post_rst_user",    bus.user_bits_o, 4'h5);
      check("post_rst_err_cnt", bus.err_cnt_o,   0);

      repeat (4) @(negedge clk_x4_i);
      check("events_pending", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
